gcd_feeder: RTL and testbench

- Upstream sequencer for the subtractive GCD datapath/controller pair.
- Accepts operand pairs on a valid/ready input and buffers them in a small FIFO.
- Drives the GCD unit's shared operand bus and start line with correct A-then-B timing, waits for done, then returns the GCD unit to its load state.
- Presents each result on a valid/ready output; zero operands (which hang a subtractive GCD) are resolved locally.

---
 rtl/gcd_feeder.sv | 183 ++++++++++++++++++
 tb/tb_gcd_feeder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_feeder.sv
// gcd_feeder: upstream sequencer for a subtractive GCD datapath/controller.
// Buffers operand pairs in a small FIFO, drives the GCD unit's shared operand
// bus (A on the start cycle, B on the following cycle), waits for done or a
// timeout, then presents the result on a valid/ready output. Pairs with a
// zero operand never reach the GCD unit; their result is formed here.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   CLR    | pulse gcd_clr for one cycle, returning the GCD unit to load-A
//   IDLE   | wait for a queued pair; pop it into the holding registers
//   LOAD_A | gcd_start = 1, operand bus carries A
//   LOAD_B | operand bus carries B, timeout counter cleared
//   WAIT   | operand bus holds B, count cycles until done or timeout
//   HOLD   | out_valid = 1, result held until the consumer takes it
module gcd_feeder #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             gcd_clr,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data_in,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_CLR    = 3'd0,
    S_IDLE   = 3'd1,
    S_LOAD_A = 3'd2,
    S_LOAD_B = 3'd3,
    S_WAIT   = 3'd4,
    S_HOLD   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] fifo_a [DEPTH];
  logic [WIDTH-1:0] fifo_b [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             full, empty;
  logic             push, pop;
  logic [WIDTH-1:0] head_a, head_b;
  logic             head_zero;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic [TW-1:0]    tmo_cnt;
  logic             timeout_hit;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full && !rst;
  assign push      = in_valid && in_ready;
  assign pop       = (state == S_IDLE) && !empty;
  assign head_a    = fifo_a[rd_ptr];
  assign head_b    = fifo_b[rd_ptr];
  assign head_zero = (head_a == '0) || (head_b == '0);

  // Last WAIT cycle before the abort: counter started at 0 on WAIT entry.
  assign timeout_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  // FIFO storage: contents are don't-care while the entry is not occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= in_a;
      fifo_b[wr_ptr] <= in_b;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_CLR;
    else     state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_CLR:    state_nxt = S_IDLE;
      S_IDLE: begin
        if (!empty) state_nxt = head_zero ? S_HOLD : S_LOAD_A;
      end
      S_LOAD_A: state_nxt = S_LOAD_B;
      S_LOAD_B: state_nxt = S_WAIT;
      S_WAIT: begin
        if (gcd_done || timeout_hit) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) state_nxt = S_CLR;
      end
      default:  state_nxt = S_CLR;
    endcase
  end

  // FSM outputs: GCD unit control, operand bus and status.
  always_comb begin
    gcd_clr     = 1'b0;
    gcd_start   = 1'b0;
    gcd_data_in = '0;
    out_valid   = 1'b0;
    case (state)
      S_CLR:    gcd_clr = 1'b1;
      S_LOAD_A: begin
        gcd_start   = 1'b1;
        gcd_data_in = a_reg;
      end
      S_LOAD_B: gcd_data_in = b_reg;
      S_WAIT:   gcd_data_in = b_reg;
      S_HOLD:   out_valid = 1'b1;
      default:  ;
    endcase
  end

  assign busy = (state != S_IDLE) || !empty;

  // Holding registers, timeout counter and the result registers. The result
  // is only written on entry to HOLD, so it stays put while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      tmo_cnt <= '0;
      out_gcd <= '0;
      out_err <= 1'b0;
    end else begin
      if (pop) begin
        a_reg <= head_a;
        b_reg <= head_b;
        if (head_zero) begin
          out_gcd <= head_a | head_b;
          out_err <= 1'b0;
        end
      end
      if (state == S_LOAD_B) tmo_cnt <= '0;
      if (state == S_WAIT) begin
        if (gcd_done) begin
          out_gcd <= gcd_result;
          out_err <= 1'b0;
        end else if (timeout_hit) begin
          out_gcd <= '0;
          out_err <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_gcd_feeder.sv
// Directed bench for gcd_feeder with a behavioural GCD unit that loads A on
// gcd_start, B on the next cycle, and raises a sticky done after a delay.
module tb_gcd_feeder;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic             gcd_clr, gcd_start;
  logic [WIDTH-1:0] gcd_data_in;
  logic             gcd_done;
  logic [WIDTH-1:0] gcd_result;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_gcd;
  logic             out_err;
  logic             busy;

  int errors = 0;
  int checks = 0;

  // GCD unit model
  logic [WIDTH-1:0] m_a, m_b, m_res, jitter;
  logic [1:0]       m_phase;
  logic             m_done;
  int               m_cnt;
  int               m_delay = 5;
  logic             m_hang = 1'b0;
  int               start_count = 0;

  gcd_feeder #(.WIDTH(WIDTH), .DEPTH(4), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .gcd_clr(gcd_clr), .gcd_start(gcd_start), .gcd_data_in(gcd_data_in),
    .gcd_done(gcd_done), .gcd_result(gcd_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
    .out_err(out_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [WIDTH-1:0] gcd_ref(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] p, q, t;
    p = x;
    q = y;
    while (q != '0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  assign gcd_done   = m_done;
  assign gcd_result = m_res ^ jitter;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 2'd0;
      m_done  <= 1'b0;
      m_res   <= '0;
      m_a     <= '0;
      m_b     <= '0;
      m_cnt   <= 0;
    end else if (gcd_clr) begin
      m_phase <= 2'd0;
      m_done  <= 1'b0;
    end else begin
      case (m_phase)
        2'd0: if (gcd_start) begin
          m_a     <= gcd_data_in;
          m_phase <= 2'd1;
        end
        2'd1: begin
          m_b     <= gcd_data_in;
          m_cnt   <= m_delay;
          m_phase <= 2'd2;
        end
        2'd2: begin
          if (m_cnt == 0) begin
            if (!m_hang) begin
              m_done <= 1'b1;
              m_res  <= gcd_ref(m_a, m_b);
            end
            m_phase <= 2'd3;
          end else begin
            m_cnt <= m_cnt - 1;
          end
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) if (gcd_start) start_count <= start_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; a pending offer that was accepted on this edge is withdrawn.
  task automatic tick();
    logic acc;
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (acc) in_valid = 1'b0;
  endtask

  task automatic push(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    n = 0;
    while (in_valid && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_accepted"}, {31'd0, in_valid}, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    check({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_clr"}, {31'd0, gcd_clr}, 32'd1);
    out_ready = 1'b0;
    tick();
    check({tag, "_clr_once"}, {31'd0, gcd_clr}, 32'd0);
  endtask

  logic [WIDTH-1:0] va [6];
  logic [WIDTH-1:0] vb [6];
  logic [WIDTH-1:0] vg [6];
  int start_base;
  int n;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0; jitter = '0;
    va[0] = 48;  vb[0] = 36; vg[0] = 12;
    va[1] = 35;  vb[1] = 14; vg[1] = 7;
    va[2] = 27;  vb[2] = 9;  vg[2] = 9;
    va[3] = 17;  vb[3] = 5;  vg[3] = 1;
    va[4] = 100; vb[4] = 75; vg[4] = 25;
    va[5] = 64;  vb[5] = 48; vg[5] = 16;

    // 1: reset values and one ordinary pair
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_start", {31'd0, gcd_start}, 32'd0);
    check("rst_data", {16'd0, gcd_data_in}, 32'd0);
    check("rst_out_gcd", {16'd0, out_gcd}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    check("post_rst_clr", {31'd0, gcd_clr}, 32'd1);
    tick();
    check("idle_clr_low", {31'd0, gcd_clr}, 32'd0);
    check("idle_not_busy", {31'd0, busy}, 32'd0);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    push("t1_push", 16'd48, 16'd18);
    check("t1_busy", {31'd0, busy}, 32'd1);
    tick();
    check("t1_load_a_start", {31'd0, gcd_start}, 32'd1);
    check("t1_load_a_data", {16'd0, gcd_data_in}, 32'd48);
    tick();
    check("t1_load_b_start", {31'd0, gcd_start}, 32'd0);
    check("t1_load_b_data", {16'd0, gcd_data_in}, 32'd18);
    tick();
    check("t1_wait_data", {16'd0, gcd_data_in}, 32'd18);
    check("t1_wait_invalid", {31'd0, out_valid}, 32'd0);
    wait_valid("t1", 40);
    check("t1_gcd", {16'd0, out_gcd}, 32'd6);
    check("t1_err", {31'd0, out_err}, 32'd0);
    handshake("t1");

    // 2: fill the FIFO with the consumer stalled, then drain in order
    m_delay = 3;
    for (int i = 0; i < 5; i++) push("t2_push", va[i], vb[i]);
    check("t2_full_ready", {31'd0, in_ready}, 32'd0);
    in_a = va[5];
    in_b = vb[5];
    in_valid = 1'b1;
    tick();
    tick();
    tick();
    check("t2_blocked", {31'd0, in_valid}, 32'd1);
    check("t2_blocked_ready", {31'd0, in_ready}, 32'd0);
    for (int r = 0; r < 6; r++) begin
      wait_valid("t2", 100);
      check($sformatf("t2_gcd%0d", r), {16'd0, out_gcd}, {16'd0, vg[r]});
      check($sformatf("t2_err%0d", r), {31'd0, out_err}, 32'd0);
      handshake("t2");
    end
    check("t2_late_accept", {31'd0, in_valid}, 32'd0);
    in_valid = 1'b0;
    tick();
    check("t2_drained", {31'd0, busy}, 32'd0);

    // 3: zero operands resolved locally
    start_base = start_count;
    push("t3_push0", 16'd0, 16'd35);
    push("t3_push1", 16'd0, 16'd0);
    wait_valid("t3a", 40);
    check("t3_gcd_0_35", {16'd0, out_gcd}, 32'd35);
    check("t3_err_a", {31'd0, out_err}, 32'd0);
    handshake("t3a");
    wait_valid("t3b", 40);
    check("t3_gcd_0_0", {16'd0, out_gcd}, 32'd0);
    check("t3_err_b", {31'd0, out_err}, 32'd0);
    handshake("t3b");
    check("t3_no_start", start_count - start_base, 32'd0);

    // 4: GCD unit never finishes -> abort after 20 WAIT cycles
    m_hang = 1'b1;
    push("t4_push", 16'd12, 16'd8);
    n = 0;
    while (!gcd_start && n < 20) begin
      tick();
      n++;
    end
    check("t4_start", {31'd0, gcd_start}, 32'd1);
    tick();
    tick();
    repeat (19) tick();
    check("t4_wait19", {31'd0, out_valid}, 32'd0);
    tick();
    check("t4_wait20", {31'd0, out_valid}, 32'd1);
    check("t4_err", {31'd0, out_err}, 32'd1);
    check("t4_gcd", {16'd0, out_gcd}, 32'd0);
    handshake("t4");
    m_hang = 1'b0;

    // 5: result stable while the consumer stalls and gcd_result moves
    push("t5_push", 16'd60, 16'd84);
    wait_valid("t5", 40);
    check("t5_gcd", {16'd0, out_gcd}, 32'd12);
    for (int i = 0; i < 10; i++) begin
      jitter = WIDTH'(i + 1);
      tick();
      check($sformatf("t5_hold%0d_gcd", i), {16'd0, out_gcd}, 32'd12);
      check($sformatf("t5_hold%0d_valid", i), {31'd0, out_valid}, 32'd1);
    end
    jitter = '0;
    handshake("t5");
    check("t5_single_xfer", {31'd0, out_valid}, 32'd0);

    // 6: reset in WAIT with two pairs still queued
    m_delay = 10;
    push("t6_push0", 16'd9, 16'd6);
    push("t6_push1", 16'd30, 16'd20);
    push("t6_push2", 16'd21, 16'd14);
    tick();
    check("t6_in_wait", {16'd0, gcd_data_in}, 32'd6);
    check("t6_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_data", {16'd0, gcd_data_in}, 32'd0);
    check("t6_rst_ready", {31'd0, in_ready}, 32'd0);
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    tick();
    rst = 1'b0;
    check("t6_first_clr", {31'd0, gcd_clr}, 32'd1);
    tick();
    check("t6_idle_empty", {31'd0, busy}, 32'd0);
    tick();
    check("t6_no_start", {31'd0, gcd_start}, 32'd0);
    check("t6_still_idle", {31'd0, busy}, 32'd0);
    check("t6_no_valid", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
